// File: rtl/gemv_pkg.sv
// Shared types, default widths and saturation helpers for the tiled GEMV engine.
package gemv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_MAX_ROWS   = 128;
  localparam int DEF_MAX_COLS   = 128;
  localparam int DEF_TILE_SIZE  = 32;
  localparam int DEF_MULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    QUANT = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Largest value representable in a signed dw-bit result
  function automatic longint sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed dw-bit result
  function automatic longint sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/gemv_stream_engine_requant.sv
// Static requantization: bias add, unsigned multiply, round-half-up shift,
// saturation to the result width and optional ReLU. Purely combinational.
module requant_unit
  import gemv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MULT_WIDTH = DEF_MULT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] bias_val,
  input  logic        [MULT_WIDTH-1:0] q_mult,
  input  logic        [5:0]            q_shift,
  input  logic                         relu_en,
  output logic        [DATA_WIDTH-1:0] y
);

  localparam int PW = ACC_WIDTH + MULT_WIDTH + 1;
  localparam logic signed [PW-1:0] Y_MAX = PW'(sat_max(DATA_WIDTH));
  localparam logic signed [PW-1:0] Y_MIN = PW'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [PW-1:0]         prod_s;
  logic signed [PW-1:0]         rnd_s;
  logic signed [PW-1:0]         shifted_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  // Bias add, scale, round, clamp and rectify one accumulated row
  always_comb begin
    sum_s  = acc + ACC_WIDTH'(bias_val);
    prod_s = PW'(sum_s) * $signed({1'b0, q_mult});
    if (q_shift != 6'd0) begin
      rnd_s     = PW'(64'sd1) <<< (q_shift - 6'd1);
      shifted_s = (prod_s + rnd_s) >>> q_shift;
    end else begin
      rnd_s     = '0;
      shifted_s = prod_s;
    end
    if (shifted_s > Y_MAX) begin
      sat_s = Y_MAX[DATA_WIDTH-1:0];
    end else if (shifted_s < Y_MIN) begin
      sat_s = Y_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_s = shifted_s[DATA_WIDTH-1:0];
    end
    if (relu_en && sat_s[DATA_WIDTH-1]) begin
      y = '0;
    end else begin
      y = sat_s;
    end
  end

endmodule

// File: rtl/gemv_stream_engine.sv
// Tiled int8 GEMV: accumulates one weight tile per handshake against a masked
// slice of x, then requantizes each finished row and streams it out.
module gemv_stream_engine
  import gemv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MAX_ROWS   = DEF_MAX_ROWS,
  parameter int MAX_COLS   = DEF_MAX_COLS,
  parameter int TILE_SIZE  = DEF_TILE_SIZE,
  parameter int MULT_WIDTH = DEF_MULT_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [9:0]                             rows,
  input  logic [9:0]                             cols,
  input  logic                                   relu_en,
  input  logic [MULT_WIDTH-1:0]                  q_mult,
  input  logic [5:0]                             q_shift,
  input  logic [MAX_COLS-1:0][DATA_WIDTH-1:0]    x,
  input  logic [MAX_ROWS-1:0][DATA_WIDTH-1:0]    bias,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]   w_tile_in,
  output logic                                   y_valid,
  input  logic                                   y_ready,
  output logic [DATA_WIDTH-1:0]                  y_data,
  output logic [$clog2(MAX_ROWS)-1:0]            y_row,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int ROW_W = $clog2(MAX_ROWS);
  localparam int COL_W = $clog2(MAX_COLS);

  state_e                       state_q, state_d;
  logic [9:0]                   rows_q, rows_d, cols_q, cols_d;
  logic [9:0]                   row_q, row_d, tile_q, tile_d;
  logic                         relu_q, relu_d;
  logic [MULT_WIDTH-1:0]        mult_q, mult_d;
  logic [5:0]                   shift_q, shift_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         w_ready_q, w_ready_d, y_valid_q, y_valid_d;
  logic                         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]        y_data_q, y_data_d;
  logic [ROW_W-1:0]             y_row_q, y_row_d;

  logic signed [ACC_WIDTH-1:0]    dot_s;
  logic [9:0]                     col_s;
  logic signed [DATA_WIDTH-1:0]   xv_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic [9:0]                     n_tiles_s;
  logic                           last_tile_s, cfg_bad_s;
  logic signed [DATA_WIDTH-1:0]   bias_row_s;
  logic [DATA_WIDTH-1:0]          rq_y_s;

  // Dot product of the incoming tile with x; lanes past the last column see x=0
  always_comb begin
    dot_s  = '0;
    col_s  = '0;
    xv_s   = '0;
    prod_s = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      col_s = 10'(int'(tile_q) * TILE_SIZE + i);
      if (col_s < cols_q) begin
        xv_s = $signed(x[col_s[COL_W-1:0]]);
      end else begin
        xv_s = '0;
      end
      prod_s = $signed(w_tile_in[i]) * xv_s;
      dot_s  = dot_s + ACC_WIDTH'(prod_s);
    end
  end

  // Row geometry, config legality and the bias of the row being finished
  always_comb begin
    n_tiles_s   = 10'((int'(cols_q) + TILE_SIZE - 1) / TILE_SIZE);
    last_tile_s = (tile_q == n_tiles_s - 10'd1);
    cfg_bad_s   = (rows == 10'd0) || (cols == 10'd0) ||
                  (rows > 10'(MAX_ROWS)) || (cols > 10'(MAX_COLS));
    bias_row_s  = $signed(bias[row_q[ROW_W-1:0]]);
  end

  requant_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .MULT_WIDTH (MULT_WIDTH)
  ) u_requant (
    .acc      (acc_q),
    .bias_val (bias_row_s),
    .q_mult   (mult_q),
    .q_shift  (shift_q),
    .relu_en  (relu_q),
    .y        (rq_y_s)
  );

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_d     = row_q;
    tile_d    = tile_q;
    relu_d    = relu_q;
    mult_d    = mult_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_row_d   = y_row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = rows;
          cols_d  = cols;
          relu_d  = relu_en;
          mult_d  = q_mult;
          shift_d = q_shift;
          acc_d   = '0;
          row_d   = '0;
          tile_d  = '0;
          if (cfg_bad_s) begin
            state_d = ERR;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (w_valid && w_ready_q) begin
          acc_d = acc_q + dot_s;
          if (last_tile_s) begin
            state_d = QUANT;
          end else begin
            tile_d = tile_q + 10'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      QUANT: begin
        y_data_d  = rq_y_s;
        y_row_d   = row_q[ROW_W-1:0];
        y_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          if (row_q == rows_q - 10'd1) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 10'd1;
            tile_d  = '0;
            acc_d   = '0;
            state_d = RUN;
          end
        end else begin
          y_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    w_ready_d = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) || (state_d == ERR);
    err_d     = (state_d == ERR);
  end

  // State and output registers; reset drops any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      tile_q    <= '0;
      relu_q    <= 1'b0;
      mult_q    <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      w_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      y_data_q  <= '0;
      y_row_q   <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_q     <= row_d;
      tile_q    <= tile_d;
      relu_q    <= relu_d;
      mult_q    <= mult_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      w_ready_q <= w_ready_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      y_data_q  <= y_data_d;
      y_row_q   <= y_row_d;
    end
  end

  assign w_ready = w_ready_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_row   = y_row_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gemv_stream_engine.sv
// Scoreboard bench for gemv_stream_engine: a reference model pushes expected
// rows as weights are driven; a monitor pops and compares on each y handshake.
module tb_gemv_stream_engine;

  localparam int DW = 8;
  localparam int MR = 128;
  localparam int MC = 128;
  localparam int TS = 32;
  localparam int MW = 16;

  logic                   clk = 1'b0;
  logic                   rst, start, relu_en, w_valid, y_ready;
  logic [9:0]             rows, cols;
  logic [MW-1:0]          q_mult;
  logic [5:0]             q_shift;
  logic [MC-1:0][DW-1:0]  x_p;
  logic [MR-1:0][DW-1:0]  bias_p;
  logic [TS-1:0][DW-1:0]  w_tile_in;
  logic                   w_ready, y_valid, busy, done, err;
  logic [DW-1:0]          y_data;
  logic [6:0]             y_row;

  logic [DW-1:0] wmem [MR][MC];

  typedef struct { int row; int data; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gemv_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .relu_en(relu_en), .q_mult(q_mult), .q_shift(q_shift), .x(x_p),
    .bias(bias_p), .w_valid(w_valid), .w_ready(w_ready), .w_tile_in(w_tile_in),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer dot product, 32-bit wrap, scale, round half up, clamp, ReLU
  function automatic int model_row(int r, int nc, int mult, int shift, bit relu);
    int acc;
    longint p;
    acc = 0;
    for (int c = 0; c < nc; c++) acc += int'($signed(wmem[r][c])) * int'($signed(x_p[c]));
    acc += int'($signed(bias_p[r]));
    p = longint'(acc) * longint'(mult);
    if (shift > 0) p = (p + (64'sd1 <<< (shift - 1))) >>> shift;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    if (relu && p < 0) p = 0;
    return int'(p);
  endfunction

  // Monitor: every accepted result must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (sb_q.size() == 0) begin
        chk("y_unexpected", int'(y_valid), 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("y_row", int'(y_row), mon_e.row);
        chk("y_data", int'($signed(y_data)), mon_e.data);
      end
    end
  end

  task automatic fill_rand(input int nr);
    for (int r = 0; r < nr; r++) begin
      bias_p[r] = 8'(int'($urandom_range(0, 63)) - 32);
      for (int c = 0; c < MC; c++) wmem[r][c] = 8'(int'($urandom_range(0, 15)) - 8);
    end
    for (int c = 0; c < MC; c++) x_p[c] = 8'(int'($urandom_range(0, 15)) - 8);
  endtask

  task automatic run_job(input int nr, input int nc, input int mult, input int shift,
                         input bit relu, input int bp_row, input int abort_row);
    int nt;
    nt = (nc + TS - 1) / TS;
    @(posedge clk); #1;
    rows = 10'(nr); cols = 10'(nc); q_mult = MW'(mult); q_shift = 6'(shift);
    relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < nr; r++) begin
      sb_q.push_back('{r, model_row(r, nc, mult, shift, relu)});
      for (int t = 0; t < nt; t++) begin
        for (int i = 0; i < TS; i++) w_tile_in[i] = wmem[r][t * TS + i];
        w_valid = 1'b1;
        if (r == abort_row && t == 0) begin
          rst = 1'b1; w_valid = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          chk("rst_w_ready", int'(w_ready), 0);
          chk("rst_y_valid", int'(y_valid), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_done", int'(done), 0);
          chk("rst_err", int'(err), 0);
          chk("rst_y_data", int'(y_data), 0);
          chk("rst_y_row", int'(y_row), 0);
          sb_q.delete();
          return;
        end
        @(negedge clk);
        chk("w_ready", int'(w_ready), 1);
        @(posedge clk); #1;
      end
      w_valid = 1'b0;
      if (r == bp_row) y_ready = 1'b0;
      @(negedge clk);
      chk("quant_y_valid", int'(y_valid), 0);
      chk("quant_w_ready", int'(w_ready), 0);
      @(negedge clk);
      chk("out_y_valid", int'(y_valid), 1);
      if (r == bp_row) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("bp_y_valid", int'(y_valid), 1);
          chk("bp_y_data", int'($signed(y_data)), sb_q[0].data);
          chk("bp_y_row", int'(y_row), sb_q[0].row);
          chk("bp_w_ready", int'(w_ready), 0);
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("done_no_err", int'(err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  task automatic illegal_cfg(input int nr, input int nc);
    @(posedge clk); #1;
    rows = 10'(nr); cols = 10'(nc); start = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_done", int'(done), 1);
    chk("err_err", int'(err), 1);
    chk("err_y_valid", int'(y_valid), 0);
    chk("err_w_ready", int'(w_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_clear", int'(err), 0);
    chk("err_idle", int'(busy), 0);
    chk("err_w_ready_idle", int'(w_ready), 0);
    w_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; y_ready = 1'b1; relu_en = 1'b0;
    rows = '0; cols = '0; q_mult = '0; q_shift = '0; w_tile_in = '0;
    x_p = '0; bias_p = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_w_ready", int'(w_ready), 0);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_y_data", int'(y_data), 0);
    rst = 1'b0;

    // Row-aligned tiles with masked garbage lanes and x beyond cols
    for (int c = 0; c < MC; c++) x_p[c] = 8'd7;
    x_p[0] = 8'd1; x_p[1] = 8'd2; x_p[2] = 8'd3; x_p[3] = 8'd4;
    bias_p[0] = 8'd10; bias_p[1] = 8'd0;
    for (int c = 0; c < MC; c++) begin
      wmem[0][c] = (c < 4) ? 8'd1 : 8'd5;
      wmem[1][c] = (c < 4) ? 8'hFF : 8'd5;
    end
    chk("model_row0", model_row(0, 4, 1, 0, 1'b0), 20);
    chk("model_row1", model_row(1, 4, 1, 0, 1'b0), -10);
    run_job(2, 4, 1, 0, 1'b0, -1, -1);

    // Saturation high, low and ReLU over two full tiles
    for (int c = 0; c < MC; c++) x_p[c] = 8'd1;
    bias_p[0] = 8'd0;
    for (int c = 0; c < MC; c++) wmem[0][c] = 8'd2;
    run_job(1, 64, 1, 0, 1'b0, -1, -1);
    for (int c = 0; c < MC; c++) wmem[0][c] = 8'hFE;
    run_job(1, 64, 1, 0, 1'b0, -1, -1);
    run_job(1, 64, 1, 0, 1'b1, -1, -1);

    // Rounding: 5>>1 -> 3, -5>>1 -> -2, 100*3>>2 -> 75
    bias_p[0] = 8'd0; bias_p[1] = 8'd0;
    for (int c = 0; c < MC; c++) begin
      wmem[0][c] = 8'd1;
      wmem[1][c] = 8'hFF;
    end
    run_job(2, 5, 1, 1, 1'b0, -1, -1);
    x_p[0] = 8'd10; wmem[0][0] = 8'd10;
    run_job(1, 1, 3, 2, 1'b0, -1, -1);

    // Output backpressure on the middle row
    fill_rand(3);
    run_job(3, 40, 5, 6, 1'b0, 1, -1);

    // Illegal configurations
    illegal_cfg(2, 0);
    illegal_cfg(129, 4);
    illegal_cfg(0, 4);
    illegal_cfg(2, 129);

    // Random mixed-size jobs, including a full-width one
    fill_rand(8);
    run_job(4, 70, int'($urandom_range(1, 16)), int'($urandom_range(4, 9)), 1'b0, -1, -1);
    run_job(2, 128, 9, 7, 1'b1, -1, -1);

    // Reset mid-job, weight pulses in IDLE, then a clean rerun
    fill_rand(8);
    run_job(8, 50, 7, 6, 1'b0, -1, 3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      w_valid = 1'b1;
      for (int i = 0; i < TS; i++) w_tile_in[i] = 8'h7F;
      @(negedge clk);
      chk("idle_w_ready", int'(w_ready), 0);
      chk("idle_busy_w", int'(busy), 0);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    run_job(8, 50, 7, 6, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
